// File: rtl/debounce_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// debounce_scan_ctrl_pkg
//   Shared definitions for the time-shared button debounce scheduler:
//   default channel count / threshold / tick divider, shared with the
//   single-channel debouncer, plus the width helper used to size counters.
//   Also holds the classification of a single channel visit, which is the
//   decision the shared update unit makes on every scheduler tick.
// -----------------------------------------------------------------------------
package debounce_scan_ctrl_pkg;

    // Defaults shared with the single-channel debounce block.
    localparam int DEF_N_CH     = 4;
    localparam int DEF_THRESH   = 3;
    localparam int DEF_TICK_DIV = 1;

    // clog2 with a floor of 1 bit, so a counter or index that only ever
    // holds 0 still gets a legal one-bit vector.
    function automatic int clog2_min1(input int value);
        int w;
        w = $clog2(value);
        return (w < 1) ? 1 : w;
    endfunction

    // Outcome of visiting one channel:
    //   VISIT_MATCH : synchronized input equals the debounced level
    //   VISIT_COUNT : input differs, threshold not yet reached
    //   VISIT_FLIP  : input differs for the THRESH-th consecutive visit
    typedef enum logic [1:0] {
        VISIT_MATCH = 2'd0,
        VISIT_COUNT = 2'd1,
        VISIT_FLIP  = 2'd2
    } visit_e;

endpackage : debounce_scan_ctrl_pkg

// File: rtl/debounce_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// debounce_scan_ctrl_if
//   Bundle between the board buttons / user logic and the debounce scheduler.
//   Signals:
//     en     scan enable (low freezes the scheduler)
//     btn    raw asynchronous button inputs, one bit per channel
//     level  debounced stable level per channel
//     rise   one-clock pulse when a channel settles 0->1
//     fall   one-clock pulse when a channel settles 1->0
//     ch_sel channel visited on the current scheduler tick
//   Modports:
//     master : user side, drives en/btn and observes the results
//     slave  : the scheduler itself
// -----------------------------------------------------------------------------
interface debounce_scan_ctrl_if
    import debounce_scan_ctrl_pkg::*;
#(
    parameter int N_CH = DEF_N_CH
);

    localparam int PW = clog2_min1(N_CH);

    logic            en;
    logic [N_CH-1:0] btn;
    logic [N_CH-1:0] level;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [PW-1:0]   ch_sel;

    modport master (
        output en,
        output btn,
        input  level,
        input  rise,
        input  fall,
        input  ch_sel
    );

    modport slave (
        input  en,
        input  btn,
        output level,
        output rise,
        output fall,
        output ch_sel
    );

endinterface : debounce_scan_ctrl_if

// File: rtl/debounce_scan_ctrl_tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
//   Divides clk down to the scheduler tick rate. The counter runs
//   0..TICK_DIV-1 while en is high and holds its value while en is low, so
//   re-enabling resumes exactly where the scan was frozen.
//   Ports:
//     clk  in   system clock
//     rst  in   asynchronous active-high reset
//     en   in   count enable
//     tick out  high for the clk cycle in which the scheduler advances
// -----------------------------------------------------------------------------
module tick_prescaler
    import debounce_scan_ctrl_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int            DW   = clog2_min1(TICK_DIV);
    localparam logic [DW-1:0] LAST = DW'(TICK_DIV - 1);

    logic [DW-1:0] div_q;

    // With TICK_DIV = 1 the counter sits at 0 == LAST, so tick follows en.
    assign tick = en && (div_q == LAST);

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of block evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q <= '0;
        end else if (en) begin
            div_q <= (div_q == LAST) ? '0 : div_q + 1'b1;
        end
    end

endmodule : tick_prescaler

// File: rtl/debounce_scan_ctrl.sv
// -----------------------------------------------------------------------------
// debounce_scan_ctrl
//   Time-shared debouncer for N_CH push-buttons. A single compare/increment
//   unit visits the channels round-robin, one per scheduler tick, and keeps a
//   per-channel run-length count in a small register array. A channel flips
//   its debounced level after THRESH consecutive visits that disagree with it;
//   any agreeing visit clears the count, so glitches shorter than THRESH
//   visits never produce an event.
//   Parameters:
//     N_CH     number of button channels (>= 1)
//     THRESH   consecutive differing visits needed to flip a channel (>= 1)
//     TICK_DIV clk cycles per scheduler tick (>= 1)
//   Ports:
//     clk  in   system clock, rising edge
//     rst  in   asynchronous active-high reset
//     bus  slave modport: en, btn in; level, rise, fall, ch_sel out
// -----------------------------------------------------------------------------
module debounce_scan_ctrl
    import debounce_scan_ctrl_pkg::*;
#(
    parameter int N_CH     = DEF_N_CH,
    parameter int THRESH   = DEF_THRESH,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic                 clk,
    input  logic                 rst,
    debounce_scan_ctrl_if.slave  bus
);

    localparam int            PW      = clog2_min1(N_CH);
    localparam int            CW      = clog2_min1(THRESH);
    localparam logic [PW-1:0] LAST_CH = PW'(N_CH - 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(THRESH - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronizer per channel; only sync_q2 is used downstream.
    // ------------------------------------------------------------------
    logic [N_CH-1:0] sync_q1;
    logic [N_CH-1:0] sync_q2;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q1 <= '0;
            sync_q2 <= '0;
        end else begin
            sync_q1 <= bus.btn;
            sync_q2 <= sync_q1;
        end
    end

    // ------------------------------------------------------------------
    // Scheduler tick. The synchronizers above keep running while en is
    // low; only the prescaler and the scan state freeze.
    // ------------------------------------------------------------------
    logic tick;

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .tick (tick)
    );

    // ------------------------------------------------------------------
    // Scan state
    // ------------------------------------------------------------------
    logic [PW-1:0]   ptr;
    logic [CW-1:0]   cnt [N_CH];
    logic [N_CH-1:0] level_q;
    logic [N_CH-1:0] rise_q;
    logic [N_CH-1:0] fall_q;

    // ------------------------------------------------------------------
    // Shared update unit: select the visited channel and classify it.
    // ------------------------------------------------------------------
    logic          s_cur;
    logic          level_cur;
    logic [CW-1:0] cnt_cur;
    visit_e        visit;

    // NOTE: every signal driven here gets a value on every path (the
    // if/else chain is complete), so no latches are inferred.
    always_comb begin
        s_cur     = sync_q2[ptr];
        level_cur = level_q[ptr];
        cnt_cur   = cnt[ptr];
        if (s_cur == level_cur) begin
            visit = VISIT_MATCH;
        end else if (cnt_cur == CNT_MAX) begin
            visit = VISIT_FLIP;
        end else begin
            visit = VISIT_COUNT;
        end
    end

    // NOTE: the count array is small and lives in flops, so it is cleared
    // by reset; this is what discards a pending count on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            level_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            // Pulses last exactly one clk; the flip below overrides one bit.
            rise_q <= '0;
            fall_q <= '0;
            if (tick) begin
                unique case (visit)
                    VISIT_MATCH: begin
                        cnt[ptr] <= '0;
                    end
                    VISIT_COUNT: begin
                        cnt[ptr] <= cnt_cur + 1'b1;
                    end
                    VISIT_FLIP: begin
                        cnt[ptr]     <= '0;
                        level_q[ptr] <= s_cur;
                        rise_q[ptr]  <= s_cur;
                        fall_q[ptr]  <= ~s_cur;
                    end
                    default: begin
                        cnt[ptr] <= '0;
                    end
                endcase
                ptr <= (ptr == LAST_CH) ? '0 : ptr + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs (all registered)
    // ------------------------------------------------------------------
    assign bus.level  = level_q;
    assign bus.rise   = rise_q;
    assign bus.fall   = fall_q;
    assign bus.ch_sel = ptr;

endmodule : debounce_scan_ctrl
